// File: rtl/nios_debug_sysclk_action_decoder_if.sv
// Debug-slave bus between the TCK-domain shift register and the clk-domain decoder.
// The master side drives the strobes and shift data. The slave side returns the captures and the pulses.
interface nios_debug_sysclk_action_decoder_if #(
  parameter int unsigned JDO_W = 38,
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       ir_in;
  logic [JDO_W-1:0] sr;
  logic             vs_udr;
  logic             vs_uir;
  logic [JDO_W-1:0] jdo;
  logic [1:0]       ir;
  logic             take_action_ocimem_a;
  logic             take_action_ocimem_b;
  logic             take_no_action_ocimem_a;
  logic             take_action_break_a;
  logic             take_action_break_b;
  logic             take_action_break_c;
  logic             take_no_action_break_a;
  logic             take_no_action_break_b;
  logic             take_no_action_break_c;
  logic             take_action_tracectrl;
  logic [CNT_W-1:0] update_count;

  modport master (
    output ir_in, sr, vs_udr, vs_uir,
    input  jdo, ir, update_count,
    input  take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  take_action_break_a, take_action_break_b, take_action_break_c,
    input  take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
    input  take_action_tracectrl
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir,
    output jdo, ir, update_count,
    output take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output take_action_break_a, take_action_break_b, take_action_break_c,
    output take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
    output take_action_tracectrl
  );
endinterface

// File: rtl/nios_debug_sysclk_action_decoder.sv
// System-clock half of the Nios II JTAG debug slave.
// It synchronises the update strobes, captures jdo and ir, and emits one-cycle action pulses.
module nios_debug_sysclk_action_decoder #(
  parameter int unsigned SYNC_DEPTH = 2,
  parameter int unsigned JDO_W      = 38,
  parameter int unsigned CNT_W      = 8
) (
  input logic clk,
  input logic reset,
  nios_debug_sysclk_action_decoder_if.slave dbg
);

  localparam int unsigned P_OCI_A   = 0;
  localparam int unsigned P_OCI_B   = 1;
  localparam int unsigned P_NOCI_A  = 2;
  localparam int unsigned P_BRK_A   = 3;
  localparam int unsigned P_BRK_B   = 4;
  localparam int unsigned P_BRK_C   = 5;
  localparam int unsigned P_NBRK_A  = 6;
  localparam int unsigned P_NBRK_B  = 7;
  localparam int unsigned P_NBRK_C  = 8;
  localparam int unsigned P_TRACE   = 9;

  logic [SYNC_DEPTH-1:0] udr_sync_q, uir_sync_q;
  logic                  udr_hist_q, uir_hist_q;
  logic                  udr_edge, uir_edge;
  logic [JDO_W-1:0]      jdo_q;
  logic [1:0]            ir_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  capture_q;
  logic [9:0]            pulse_q, pulse_d;

  // Chains and history flops reset high, so a strobe that is already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_q <= '1;
      uir_sync_q <= '1;
      udr_hist_q <= 1'b1;
      uir_hist_q <= 1'b1;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_DEPTH-2:0], dbg.vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_DEPTH-2:0], dbg.vs_uir};
      udr_hist_q <= udr_sync_q[SYNC_DEPTH-1];
      uir_hist_q <= uir_sync_q[SYNC_DEPTH-1];
    end
  end

  assign udr_edge = udr_sync_q[SYNC_DEPTH-1] & ~udr_hist_q;
  assign uir_edge = uir_sync_q[SYNC_DEPTH-1] & ~uir_hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q     <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      capture_q <= 1'b0;
      pulse_q   <= '0;
    end else begin
      if (udr_edge) begin
        jdo_q <= dbg.sr;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (uir_edge) ir_q <= dbg.ir_in;
      capture_q <= udr_edge;
      pulse_q   <= pulse_d;
    end
  end

  // Decode is based on the registered jdo and ir. A simultaneous update-IR is therefore already visible here.
  always_comb begin
    logic is_oci, is_brk, is_trc;
    is_oci = capture_q & (ir_q == 2'b00);
    is_brk = capture_q & (ir_q == 2'b10);
    is_trc = capture_q & (ir_q == 2'b11);
    pulse_d           = '0;
    pulse_d[P_OCI_B]  = is_oci &  jdo_q[35];
    pulse_d[P_OCI_A]  = is_oci & ~jdo_q[35] &  jdo_q[34];
    pulse_d[P_NOCI_A] = is_oci & ~jdo_q[35] & ~jdo_q[34];
    pulse_d[P_BRK_A]  = is_brk &  jdo_q[37] & ~jdo_q[36] & ~jdo_q[35];
    pulse_d[P_BRK_B]  = is_brk &  jdo_q[37] & ~jdo_q[36] &  jdo_q[35];
    pulse_d[P_BRK_C]  = is_brk &  jdo_q[37] &  jdo_q[36];
    pulse_d[P_NBRK_A] = is_brk & ~jdo_q[37] & ~jdo_q[36] & ~jdo_q[35];
    pulse_d[P_NBRK_B] = is_brk & ~jdo_q[37] & ~jdo_q[36] &  jdo_q[35];
    pulse_d[P_NBRK_C] = is_brk & ~jdo_q[37] &  jdo_q[36];
    pulse_d[P_TRACE]  = is_trc &  jdo_q[15];
  end

  assign dbg.jdo                     = jdo_q;
  assign dbg.ir                      = ir_q;
  assign dbg.update_count            = cnt_q;
  assign dbg.take_action_ocimem_a    = pulse_q[P_OCI_A];
  assign dbg.take_action_ocimem_b    = pulse_q[P_OCI_B];
  assign dbg.take_no_action_ocimem_a = pulse_q[P_NOCI_A];
  assign dbg.take_action_break_a     = pulse_q[P_BRK_A];
  assign dbg.take_action_break_b     = pulse_q[P_BRK_B];
  assign dbg.take_action_break_c     = pulse_q[P_BRK_C];
  assign dbg.take_no_action_break_a  = pulse_q[P_NBRK_A];
  assign dbg.take_no_action_break_b  = pulse_q[P_NBRK_B];
  assign dbg.take_no_action_break_c  = pulse_q[P_NBRK_C];
  assign dbg.take_action_tracectrl   = pulse_q[P_TRACE];

endmodule

// File: tb/tb_nios_debug_sysclk_action_decoder.sv
// Bench for nios_debug_sysclk_action_decoder.
// It uses fixed vectors, hand sequences and random transactions, all checked against a rule-level model.
module tb_nios_debug_sysclk_action_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_debug_sysclk_action_decoder_if #(.JDO_W(38), .CNT_W(8)) bus ();

  nios_debug_sysclk_action_decoder #(.SYNC_DEPTH(2), .JDO_W(38), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [9:0] exp_p [int];
  logic [7:0] exp_cnt = '0;
  logic [1:0] cur_ir = '0;
  logic [9:0] pulses;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit order: 0 ocimem_a, 1 ocimem_b, 2 no_ocimem_a, 3..5 break_a..c, 6..8 no_break_a..c, 9 tracectrl
  assign pulses = {bus.take_action_tracectrl, bus.take_no_action_break_c, bus.take_no_action_break_b,
                   bus.take_no_action_break_a, bus.take_action_break_c, bus.take_action_break_b,
                   bus.take_action_break_a, bus.take_no_action_ocimem_a, bus.take_action_ocimem_b,
                   bus.take_action_ocimem_a};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [9:0] model(input logic [1:0] irv, input logic [37:0] d);
    logic [9:0] r;
    int variant;
    r = '0;
    case (irv)
      2'b00: r[d[35] ? 1 : (d[34] ? 0 : 2)] = 1'b1;
      2'b10: begin
        variant = d[36] ? 2 : (d[35] ? 1 : 0);
        r[(d[37] ? 3 : 6) + variant] = 1'b1;
      end
      2'b11: r[9] = d[15];
      default: r = '0;
    endcase
    return r;
  endfunction

  // The pulse vector is checked in every cycle. Only cycles that were scheduled by a capture may be non-zero.
  always @(negedge clk) begin
    logic [9:0] ev;
    if (chk_en) begin
      ev = exp_p.exists(cyc) ? exp_p[cyc] : '0;
      chk("pulses", {54'd0, pulses}, {54'd0, ev});
    end
  end

  // mode 0: DR update only. mode 1: IR update first, then DR. mode 2: IR and DR strobes rise together.
  task automatic xact(input logic [1:0] irv, input int mode, input logic [37:0] srv,
                      input logic [9:0] expv, input string nm);
    int e;
    if (mode == 1) begin
      @(posedge clk); #1;
      bus.ir_in = irv; bus.vs_uir = 1'b1;
      repeat (3) @(posedge clk); #1;
      bus.vs_uir = 1'b0;
      chk({nm, " ir"}, 64'(bus.ir), 64'(irv));
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    e = cyc;
    bus.sr = srv; bus.vs_udr = 1'b1;
    if (mode == 2) begin
      bus.ir_in = irv; bus.vs_uir = 1'b1;
    end
    exp_p[e + 4] = expv;
    repeat (3) @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    if (mode != 0) cur_ir = irv;
    chk({nm, " jdo"}, 64'(bus.jdo), 64'(srv));
    chk({nm, " count"}, 64'(bus.update_count), 64'(exp_cnt));
    if (mode != 0) chk({nm, " ir"}, 64'(bus.ir), 64'(irv));
    bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    logic [1:0]  irv;
    logic [37:0] srv;
    logic [9:0]  expv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int e;
    logic [37:0] a, b, r;
    logic [1:0]  ri;
    int m;

    vecs[0]  = '{2'b10, 38'h20_0000_0000, 10'h008};
    vecs[1]  = '{2'b00, 38'h0C_0000_0000, 10'h002};
    vecs[2]  = '{2'b00, 38'h00_0000_0000, 10'h004};
    vecs[3]  = '{2'b00, 38'h04_0000_0000, 10'h001};
    vecs[4]  = '{2'b11, 38'h00_0000_8000, 10'h200};
    vecs[5]  = '{2'b01, 38'h00_0000_8000, 10'h000};
    vecs[6]  = '{2'b10, 38'h28_0000_0000, 10'h010};
    vecs[7]  = '{2'b10, 38'h30_0000_0000, 10'h020};
    vecs[8]  = '{2'b10, 38'h18_0000_0000, 10'h100};
    vecs[9]  = '{2'b10, 38'h00_0000_0000, 10'h040};
    vecs[10] = '{2'b10, 38'h08_0000_0000, 10'h080};
    vecs[11] = '{2'b11, 38'h3F_FFFF_7FFF, 10'h000};

    reset = 1'b1;
    bus.vs_udr = 1'b1; bus.vs_uir = 1'b1; bus.sr = '0; bus.ir_in = '0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("reset jdo", 64'(bus.jdo), 64'd0);
    chk("reset ir", 64'(bus.ir), 64'd0);
    chk("reset count", 64'(bus.update_count), 64'd0);
    bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 12; i++)
      xact(vecs[i].irv, 1, vecs[i].srv, vecs[i].expv, $sformatf("vec%0d", i));

    xact(2'b00, 1, 38'h0, 10'h004, "ir00 prep");
    xact(2'b11, 2, 38'h00_0000_8000, 10'h200, "simul uir+udr");

    // Two DR captures two cycles apart: each must produce its own capture and its own pulse.
    xact(2'b00, 1, 38'h0, 10'h004, "b2b prep");
    a = 38'h08_0000_0000; b = 38'h00_0000_0000;
    @(posedge clk); #1; e = cyc;
    bus.sr = a; bus.vs_udr = 1'b1;
    exp_p[e + 4] = model(2'b00, a);
    exp_p[e + 6] = model(2'b00, b);
    @(posedge clk); #1; bus.vs_udr = 1'b0;
    @(posedge clk); #1; bus.vs_udr = 1'b1;
    @(posedge clk); #1;
    chk("b2b jdo a", 64'(bus.jdo), 64'(a));
    bus.sr = b;
    @(posedge clk); #1; bus.vs_udr = 1'b0;
    @(posedge clk); #1;
    chk("b2b jdo b", 64'(bus.jdo), 64'(b));
    exp_cnt = exp_cnt + 8'd2;
    chk("b2b count", 64'(bus.update_count), 64'(exp_cnt));
    repeat (4) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      r  = {6'($urandom), 32'($urandom)};
      ri = 2'($urandom_range(0, 3));
      m  = $urandom_range(0, 2);
      if (m == 0) ri = cur_ir;
      xact(ri, m, r, model(ri, r), $sformatf("rand%0d", i));
    end

    // Reset arrives after a capture but before its pulse. The pulse must never appear.
    @(posedge clk); #1; e = cyc;
    bus.sr = 38'h20_0000_0000; bus.vs_udr = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("pre-reset jdo", 64'(bus.jdo), 64'h20_0000_0000);
    reset = 1'b1;
    #1;
    chk("midreset jdo", 64'(bus.jdo), 64'd0);
    chk("midreset count", 64'(bus.update_count), 64'd0);
    chk("midreset ir", 64'(bus.ir), 64'd0);
    exp_cnt = '0; cur_ir = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("post-reset jdo", 64'(bus.jdo), 64'd0);
    chk("post-reset count", 64'(bus.update_count), 64'd0);
    bus.vs_udr = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 256; i++) begin
      r = {6'($urandom), 32'($urandom)};
      xact(cur_ir, 0, r, model(cur_ir, r), "wrap");
    end
    #1;
    chk("count wrapped", 64'(bus.update_count), 64'd0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
